// File: rtl/dpram_be_pipe_pkg.sv
// Shared constants and helpers for the byte-enable dual-port RAM.
package dpram_be_pipe_pkg;

   // Same-port read-during-write behaviour selectors
   localparam int unsigned RDW_READ_FIRST  = 0;
   localparam int unsigned RDW_WRITE_FIRST = 1;
   localparam int unsigned RDW_NO_CHANGE   = 2;

   // Number of byte lanes in a word
   function automatic int unsigned lanes_of(input int unsigned data_w, input int unsigned byte_w);
      return data_w / byte_w;
   endfunction

endpackage

// File: rtl/dpram_be_pipe_if.sv
// One RAM access port: request fields from the master, read data and strobe back.
interface dpram_be_pipe_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned LANES  = 2
);
   logic              EN;
   logic              WR;
   logic [LANES-1:0]  BE;
   logic [ADDR_W-1:0] ADDR;
   logic [DATA_W-1:0] data_IN;
   logic [DATA_W-1:0] data_OUT;
   logic              VALID;

   modport master (output EN, WR, BE, ADDR, data_IN, input data_OUT, VALID);
   modport slave  (input EN, WR, BE, ADDR, data_IN, output data_OUT, VALID);
endinterface

// File: rtl/dpram_be_pipe_port_pipe.sv
// Per-port read path: read capture, read-during-write select, optional output stage, VALID.
module dpram_be_pipe_port_pipe
   import dpram_be_pipe_pkg::*;
#(
   parameter int unsigned DATA     = 16,
   parameter int unsigned RDW_MODE = RDW_READ_FIRST,
   parameter int unsigned OUT_REG  = 0
) (
   input  logic            clK,
   input  logic            rst_n,
   input  logic            en,
   input  logic            wr,
   input  logic [DATA-1:0] old_word,
   input  logic [DATA-1:0] merged_word,
   output logic [DATA-1:0] data_out,
   output logic            valid
);

   logic            cap_c;
   logic [DATA-1:0] cap_word_c;
   logic            s1_valid;
   logic [DATA-1:0] s1_data;

   // Decide whether this access returns data, and which word
   always_comb begin
      cap_c      = 1'b0;
      cap_word_c = old_word;
      if (en) begin
         if (!wr) begin
            cap_c = 1'b1;
         end else if (RDW_MODE == RDW_WRITE_FIRST) begin
            cap_c      = 1'b1;
            cap_word_c = merged_word;
         end else if (RDW_MODE == RDW_READ_FIRST) begin
            cap_c = 1'b1;
         end
      end
   end

   // First read stage; data holds when nothing is captured
   always_ff @(posedge clK or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else begin
         s1_valid <= cap_c;
         if (cap_c) s1_data <= cap_word_c;
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic            s2_valid;
      logic [DATA-1:0] s2_data;

      // Extra output stage, carries the strobe along with the data
      always_ff @(posedge clK or negedge rst_n) begin
         if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
         end else begin
            s2_valid <= s1_valid;
            if (s1_valid) s2_data <= s1_data;
         end
      end

      assign data_out = s2_data;
      assign valid    = s2_valid;
   end else begin : g_no_out_reg
      assign data_out = s1_data;
      assign valid    = s1_valid;
   end

endmodule

// File: rtl/dpram_be_pipe.sv
// True dual-port RAM with byte lanes, A-priority lane merge and same-address collision flag.
module dpram_be_pipe
   import dpram_be_pipe_pkg::*;
#(
   parameter int unsigned DATA     = 16,
   parameter int unsigned ADDR     = 5,
   parameter int unsigned BYTE     = 8,
   parameter int unsigned RDW_MODE = RDW_READ_FIRST,
   parameter int unsigned OUT_REG  = 0
) (
   input  logic           clK,
   input  logic           rst_n,
   dpram_be_pipe_if.slave a_port,
   dpram_be_pipe_if.slave b_port,
   output logic           collision
);

   localparam int unsigned LANES = lanes_of(DATA, BYTE);
   localparam int unsigned DEPTH = 1 << ADDR;

   if ((DATA % BYTE) != 0) begin : g_bad_data
      $error("dpram_be_pipe: DATA must be a multiple of BYTE");
   end
   if (RDW_MODE > RDW_NO_CHANGE) begin : g_bad_rdw
      $error("dpram_be_pipe: RDW_MODE must be 0, 1 or 2");
   end

   logic [DATA-1:0]  mem [DEPTH];
   logic             a_wr_c;
   logic             b_wr_c;
   logic             same_addr_c;
   logic [LANES-1:0] b_be_eff_c;
   logic [DATA-1:0]  a_old_c;
   logic [DATA-1:0]  b_old_c;
   logic [DATA-1:0]  a_merged_c;
   logic [DATA-1:0]  b_merged_c;

   // Write qualification, A-priority lane masking and pre-write/merged read words
   always_comb begin
      a_wr_c      = a_port.EN & a_port.WR;
      b_wr_c      = b_port.EN & b_port.WR;
      same_addr_c = (a_port.ADDR == b_port.ADDR);
      b_be_eff_c  = b_port.BE;
      if (a_wr_c && same_addr_c) b_be_eff_c = b_port.BE & ~a_port.BE;
      a_old_c    = mem[a_port.ADDR];
      b_old_c    = mem[b_port.ADDR];
      a_merged_c = a_old_c;
      b_merged_c = b_old_c;
      for (int unsigned l = 0; l < LANES; l++) begin
         if (a_port.BE[l]) a_merged_c[l*BYTE +: BYTE] = a_port.data_IN[l*BYTE +: BYTE];
         if (b_port.BE[l]) b_merged_c[l*BYTE +: BYTE] = b_port.data_IN[l*BYTE +: BYTE];
      end
   end

   // Lane-wise array update; contents survive reset, reset only blocks commits
   always_ff @(posedge clK or negedge rst_n) begin
      if (!rst_n) begin
      end else begin
         for (int unsigned l = 0; l < LANES; l++) begin
            if (b_wr_c && b_be_eff_c[l]) mem[b_port.ADDR][l*BYTE +: BYTE] <= b_port.data_IN[l*BYTE +: BYTE];
            if (a_wr_c && a_port.BE[l])  mem[a_port.ADDR][l*BYTE +: BYTE] <= a_port.data_IN[l*BYTE +: BYTE];
         end
      end
   end

   // Same-address flag: both ports active, at least one writing; a per-cycle level
   always_ff @(posedge clK or negedge rst_n) begin
      if (!rst_n) collision <= 1'b0;
      else        collision <= a_port.EN & b_port.EN & same_addr_c & (a_port.WR | b_port.WR);
   end

   dpram_be_pipe_port_pipe #(
      .DATA     (DATA),
      .RDW_MODE (RDW_MODE),
      .OUT_REG  (OUT_REG)
   ) u_a_pipe (
      .clK         (clK),
      .rst_n       (rst_n),
      .en          (a_port.EN),
      .wr          (a_port.WR),
      .old_word    (a_old_c),
      .merged_word (a_merged_c),
      .data_out    (a_port.data_OUT),
      .valid       (a_port.VALID)
   );

   dpram_be_pipe_port_pipe #(
      .DATA     (DATA),
      .RDW_MODE (RDW_MODE),
      .OUT_REG  (OUT_REG)
   ) u_b_pipe (
      .clK         (clK),
      .rst_n       (rst_n),
      .en          (b_port.EN),
      .wr          (b_port.WR),
      .old_word    (b_old_c),
      .merged_word (b_merged_c),
      .data_out    (b_port.data_OUT),
      .valid       (b_port.VALID)
   );

endmodule
